// File: rtl/str_seq_gen.sv
// str_seq_gen: AXI-stream incrementing-byte frame source.
// Byte k of every frame is (seed + k) mod 256, packed lowest lane first.
// Frame length, frame count (0 = continuous), inter-frame gap and seed are
// captured on an accepted start. i_stop lets the current frame finish, then halts.
// Optional build macro STR_SEQ_GEN_THROTTLE_EN: an LFSR gates when a new beat
// may raise tvld, which inserts pseudo-random source gaps.
// LEN_W is assumed to be at least 8.

module str_seq_gen #(
  parameter int O_WIDTH = 80,
  parameter int LEN_W   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [LEN_W-1:0]     i_byte_len,
  input  logic [15:0]          i_frame_num,
  input  logic [15:0]          i_gap,
  input  logic [7:0]           i_seed,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [15:0]          o_frame_cnt,
  output logic [O_WIDTH-1:0]   m_axis_tdata,
  output logic [O_WIDTH/8-1:0] m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvld,
  input  logic                 m_axis_trdy
);

  // state   | meaning
  // IDLE    | waiting for a start with nonzero length
  // SEND    | presenting beats of the current frame
  // GAP     | counting idle cycles between frames, tvld low
  // DONE    | one-cycle o_done pulse, then back to IDLE

  localparam int NB = O_WIDTH / 8;
  localparam logic [LEN_W-1:0] NB_L = LEN_W'(NB);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [LEN_W-1:0] len_q;
  logic [15:0]      frames_q;
  logic [15:0]      gap_q;
  logic [7:0]       seed_q;

  // off_q is the byte offset of the next beat to be loaded into the output register
  logic [LEN_W-1:0] off_q, off_d;
  logic [15:0]      gap_cnt_q, gap_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             latch_cfg;
  logic             load_en;
  logic [LEN_W-1:0] load_off;
  logic             tvld_d;
  logic             thr_ok;
  logic             hs;
  logic             frame_end;
  logic             more_frames;

  logic [LEN_W-1:0] rem;
  logic [O_WIDTH-1:0] beat_data;
  logic [NB-1:0]    beat_keep;
  logic             beat_last;

`ifdef STR_SEQ_GEN_THROTTLE_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // Free-running x^16+x^14+x^13+x^11+1 Fibonacci LFSR
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) lfsr_q <= 16'hACE1;
    else          lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
  end

  assign thr_ok = lfsr_q[0];
`else
  assign thr_ok = 1'b1;
`endif

  assign hs          = m_axis_tvld & m_axis_trdy;
  assign frame_end   = hs & m_axis_tlast;
  // frames_q == 0 runs forever; compare against the count after this frame
  assign more_frames = (frames_q == 16'd0) || ((frame_cnt_q + 16'd1) != frames_q);

  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_frame_cnt = frame_cnt_q;

  // Build the beat starting at load_off; rem is never zero when a load happens
  always_comb begin
    rem       = len_q - load_off;
    beat_last = (rem <= NB_L);
    beat_data = '0;
    beat_keep = '0;
    for (int i = 0; i < NB; i++) begin
      if (LEN_W'(i) < rem) begin
        beat_keep[i]         = 1'b1;
        beat_data[i*8 +: 8]  = seed_q + load_off[7:0] + 8'(i);
      end
    end
  end

  // Next-state, counter updates and beat-load decisions
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    tvld_d      = m_axis_tvld;
    load_en     = 1'b0;
    load_off    = off_q;
    latch_cfg   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start && (i_byte_len != '0)) begin
          state_d     = ST_SEND;
          latch_cfg   = 1'b1;
          off_d       = '0;
          frame_cnt_d = 16'd0;
          tvld_d      = 1'b0;
        end
      end

      ST_SEND: begin
        if (frame_end) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          off_d       = '0;
          tvld_d      = 1'b0;
          if (i_stop || !more_frames) begin
            state_d = ST_DONE;
          end else if (gap_q != 16'd0) begin
            state_d   = ST_GAP;
            gap_cnt_d = gap_q;
          end else if (thr_ok) begin
            // zero gap: first beat of the next frame follows the last beat directly
            load_en  = 1'b1;
            load_off = '0;
            off_d    = NB_L;
            tvld_d   = 1'b1;
          end
        end else if ((!m_axis_tvld || hs) && (off_q < len_q) && thr_ok) begin
          load_en  = 1'b1;
          load_off = off_q;
          off_d    = off_q + NB_L;
          tvld_d   = 1'b1;
        end else if (hs) begin
          tvld_d = 1'b0;
        end
      end

      ST_GAP: begin
        if (i_stop) begin
          state_d = ST_DONE;
        end else if (gap_cnt_q == 16'd1) begin
          // load on the gap's final edge so exactly gap_q idle cycles are seen
          state_d = ST_SEND;
          if (thr_ok) begin
            load_en  = 1'b1;
            load_off = '0;
            off_d    = NB_L;
            tvld_d   = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      off_q       <= '0;
      gap_cnt_q   <= 16'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Configuration captured on an accepted start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_q    <= '0;
      frames_q <= 16'd0;
      gap_q    <= 16'd0;
      seed_q   <= 8'd0;
    end else if (latch_cfg) begin
      len_q    <= i_byte_len;
      frames_q <= i_frame_num;
      gap_q    <= i_gap;
      seed_q   <= i_seed;
    end
  end

  // Output beat register; payload only changes on a load, so it holds through stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_axis_tvld  <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tlast <= 1'b0;
    end else begin
      m_axis_tvld <= tvld_d;
      if (load_en) begin
        m_axis_tdata <= beat_data;
        m_axis_tkeep <= beat_keep;
        m_axis_tlast <= beat_last;
      end
    end
  end

endmodule

// File: tb/tb_str_seq_gen.sv
// Bench for str_seq_gen: vector table of frame configurations driven through a
// beat scoreboard, plus hand sequences for stall, reset and zero-length start.

module tb_str_seq_gen;

  localparam int NB    = 10;
  localparam int LEN_W = 32;

  logic              clk;
  logic              rst_n;
  logic              i_start;
  logic              i_stop;
  logic [LEN_W-1:0]  i_byte_len;
  logic [15:0]       i_frame_num;
  logic [15:0]       i_gap;
  logic [7:0]        i_seed;
  logic              o_busy;
  logic              o_done;
  logic [15:0]       o_frame_cnt;
  logic [NB*8-1:0]   m_axis_tdata;
  logic [NB-1:0]     m_axis_tkeep;
  logic              m_axis_tlast;
  logic              m_axis_tvld;
  logic              m_axis_trdy;

  str_seq_gen #(.O_WIDTH(NB*8), .LEN_W(LEN_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_byte_len   (i_byte_len),
    .i_frame_num  (i_frame_num),
    .i_gap        (i_gap),
    .i_seed       (i_seed),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_frame_cnt  (o_frame_cnt),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvld  (m_axis_tvld),
    .m_axis_trdy  (m_axis_trdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [NB*8-1:0] data;
    logic [NB-1:0]   keep;
    logic            last;
  } beat_t;

  typedef struct {
    int         len;
    int         frames;
    int         gap;
    logic [7:0] seed;
    int         stop_at;
    int         rdy_mode;
    int         exp_frames;
  } vec_t;

  beat_t sb_q[$];
  int    gaps_q[$];
  vec_t  vecs[10];

  int n_checks = 0;
  int n_fail   = 0;
  int hs_total = 0;
  int done_cnt = 0;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: byte k of a frame is seed+k, lane i of beat b is byte b*NB+i
  task automatic push_frame(input int len, input logic [7:0] seed);
    int nbeats;
    nbeats = (len + NB - 1) / NB;
    for (int b = 0; b < nbeats; b++) begin
      beat_t e;
      e.data = '0;
      e.keep = '0;
      for (int i = 0; i < NB; i++) begin
        int k;
        k = b * NB + i;
        if (k < len) begin
          e.keep[i]        = 1'b1;
          e.data[i*8 +: 8] = seed + 8'(k);
        end
      end
      e.last = (b == nbeats - 1);
      sb_q.push_back(e);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = driven by a hand sequence
  initial begin
    m_axis_trdy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 0)      m_axis_trdy = 1'b1;
      else if (rdy_mode == 1) m_axis_trdy = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: scoreboard pops on handshakes, AXI hold rule, gap lengths, done pulses
  initial begin
    logic            prev_stall;
    logic [NB*8-1:0] prev_data;
    logic [NB-1:0]   prev_keep;
    logic            prev_last;
    logic            in_gap;
    int              gap_run;
    beat_t           e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_keep  = '0;
    prev_last  = 1'b0;
    in_gap     = 1'b0;
    gap_run    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        in_gap     = 1'b0;
      end else begin
        if (o_done) done_cnt++;
        if (prev_stall) begin
          chk("hold_tvld", m_axis_tvld, 1'b1);
          chk("hold_tdata", m_axis_tdata, prev_data);
          chk("hold_tkeep_tlast", {m_axis_tkeep, m_axis_tlast}, {prev_keep, prev_last});
        end
        if (in_gap) begin
          if (m_axis_tvld) begin
            gaps_q.push_back(gap_run);
            in_gap = 1'b0;
          end else if (!o_busy) begin
            in_gap = 1'b0;
          end else begin
            gap_run++;
          end
        end
        if (m_axis_tvld && m_axis_trdy) begin
          hs_total++;
          if (sb_q.size() == 0) begin
            chk("unexpected_beat", 1'b1, 1'b0);
          end else begin
            e = sb_q.pop_front();
            chk("beat_tdata", m_axis_tdata, e.data);
            chk("beat_tkeep", m_axis_tkeep, e.keep);
            chk("beat_tlast", m_axis_tlast, e.last);
          end
          if (m_axis_tlast) begin
            in_gap  = 1'b1;
            gap_run = 0;
          end
        end
        prev_stall = m_axis_tvld && !m_axis_trdy;
        prev_data  = m_axis_tdata;
        prev_keep  = m_axis_tkeep;
        prev_last  = m_axis_tlast;
      end
    end
  end

  // Pulse start for one cycle; returns with the start edge just passed
  task automatic do_start(input int len, input int frames, input int gap, input logic [7:0] seed);
    @(posedge clk);
    #1;
    i_byte_len  = LEN_W'(len);
    i_frame_num = 16'(frames);
    i_gap       = 16'(gap);
    i_seed      = seed;
    i_start     = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input int stop_at, input int hs_base);
    int cyc;
    cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (stop_at != 0 && (hs_total - hs_base) >= stop_at) i_stop = 1'b1;
    end
    chk({name, "_done_seen"}, (done_cnt != 0), 1'b1);
  endtask

  task automatic run_vec(input int idx);
    vec_t  v;
    int    hs_base;
    string nm;
    v  = vecs[idx];
    nm = $sformatf("v%0d", idx);
    for (int f = 0; f < v.exp_frames; f++) push_frame(v.len, v.seed);
    gaps_q.delete();
    done_cnt = 0;
    rdy_mode = v.rdy_mode;
    hs_base  = hs_total;
    do_start(v.len, v.frames, v.gap, v.seed);
    chk({nm, "_busy_after_start"}, o_busy, 1'b1);
    chk({nm, "_cnt_cleared"}, o_frame_cnt, 16'd0);
    chk({nm, "_tvld_latency0"}, m_axis_tvld, 1'b0);
    // configuration inputs are scrambled; only the captured values may matter
    i_byte_len  = $urandom;
    i_frame_num = 16'($urandom);
    i_gap       = 16'($urandom);
    i_seed      = 8'($urandom);
    @(posedge clk);
    #1;
    chk({nm, "_tvld_latency1"}, m_axis_tvld, 1'b1);
    wait_done(nm, 3000, v.stop_at, hs_base);
    i_stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_frame_cnt"}, o_frame_cnt, 16'(v.exp_frames));
    chk({nm, "_sb_empty"}, sb_q.size(), 0);
    chk({nm, "_done_once"}, done_cnt, 1);
    chk({nm, "_idle"}, {o_busy, m_axis_tvld}, 2'b00);
    chk({nm, "_gap_count"}, gaps_q.size(), v.exp_frames - 1);
    foreach (gaps_q[g]) chk({nm, "_gap_len"}, gaps_q[g], v.gap);
    sb_q.delete();
  endtask

  initial begin
    int hs_base;
    int cyc;

    //          len  frm gap seed   stop rdy exp
    vecs[0] = '{100, 1,  0,  8'h00, 0,   0,  1};
    vecs[1] = '{25,  1,  0,  8'h00, 0,   0,  1};
    vecs[2] = '{20,  3,  4,  8'h10, 1,   0,  1};
    vecs[3] = '{20,  3,  4,  8'h40, 0,   0,  3};
    vecs[4] = '{12,  1,  0,  8'hFE, 0,   0,  1};
    vecs[5] = '{37,  2,  0,  8'h5A, 0,   1,  2};
    vecs[6] = '{10,  4,  1,  8'h80, 0,   1,  4};
    vecs[7] = '{1,   2,  2,  8'h07, 0,   0,  2};
    vecs[8] = '{15,  0,  3,  8'hC3, 5,   0,  3};
    vecs[9] = '{10,  3,  6,  8'h99, 1,   0,  1};

    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_stop      = 1'b0;
    i_byte_len  = '0;
    i_frame_num = 16'd0;
    i_gap       = 16'd0;
    i_seed      = 8'd0;

    #2;
    chk("reset_ctrl", {o_busy, o_done, o_frame_cnt}, 18'd0);
    chk("reset_axis", {m_axis_tvld, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, '0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // i_stop in IDLE does nothing
    i_stop = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stop_in_idle", {o_busy, m_axis_tvld}, 2'b00);
    i_stop = 1'b0;

    for (int v = 0; v < 10; v++) run_vec(v);

    // Stall: ready low for 5 cycles while beat 2 of a 100-byte frame is presented
    push_frame(100, 8'h33);
    done_cnt = 0;
    rdy_mode = 2;
    m_axis_trdy = 1'b1;
    hs_base = hs_total;
    do_start(100, 1, 0, 8'h33);
    cyc = 0;
    while ((hs_total - hs_base) < 2 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("stall_reach_beat2", (hs_total - hs_base), 2);
    m_axis_trdy = 1'b0;
    // a start while busy must be ignored
    i_byte_len = 32'd5;
    i_seed     = 8'hAA;
    i_start    = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stall_no_handshake", (hs_total - hs_base), 2);
    chk("stall_tvld_high", m_axis_tvld, 1'b1);
    m_axis_trdy = 1'b1;
    wait_done("stall", 500, 0, hs_base);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_frame_cnt", o_frame_cnt, 16'd1);
    chk("stall_sb_empty", sb_q.size(), 0);
    chk("stall_beats", (hs_total - hs_base), 10);
    sb_q.delete();
    rdy_mode = 0;

    // Asynchronous reset in the middle of a continuous single-beat-frame run
    for (int f = 0; f < 40; f++) push_frame(10, 8'h21);
    done_cnt = 0;
    hs_base = hs_total;
    do_start(10, 0, 0, 8'h21);
    cyc = 0;
    while ((hs_total - hs_base) < 4 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rst_run_cnt_nonzero", (o_frame_cnt != 16'd0), 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {o_busy, o_done, o_frame_cnt}, 18'd0);
    chk("rst_async_axis", {m_axis_tvld, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, '0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_stays_idle", {o_busy, m_axis_tvld}, 2'b00);
    chk("rst_no_done", done_cnt, 0);

    // Zero-length start is ignored entirely
    done_cnt = 0;
    hs_base = hs_total;
    do_start(0, 1, 0, 8'h55);
    chk("len0_no_busy", o_busy, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("len0_no_output", {o_busy, m_axis_tvld, (hs_total - hs_base) != 0}, 3'b000);
    chk("len0_no_done", done_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/str_seq_gen.md
Name: str_seq_gen

Overview:
- Synthesizable AXI-stream traffic source that emits frames of incrementing-byte payload with correct tkeep/tlast. Drives the slave side of stream blocks such as the width converter, in hardware self-test and on-board loopback.
- Pattern matches the team's stream checkers: byte k of a frame = (seed + k) mod 256, packed lowest lane first.
- Supports programmable frame length, frame count, inter-frame gap and graceful stop.

Parameters:
- O_WIDTH, 80: m_axis_tdata width in bits; multiple of 8. NB = O_WIDTH/8 lanes.
- LEN_W, 32: width of the byte-length input and internal byte counter.

Ports:
- i_clk  input  1  sole clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_start  input  1  one-cycle start request; sampled only in IDLE.
- i_stop  input  1  level; finish the current frame, then halt.
- i_byte_len  input  LEN_W  bytes per frame; latched on accepted start.
- i_frame_num  input  16  frames to send; 0 = continuous until stop. Latched on start.
- i_gap  input  16  idle cycles between frames; latched on start.
- i_seed  input  8  value of byte 0 of every frame; latched on start.
- o_busy  output  1  high from accepted start until return to IDLE.
- o_done  output  1  one-cycle pulse on return to IDLE.
- o_frame_cnt  output  16  frames completed since last start; wraps at 2^16.
- m_axis_tdata  output  O_WIDTH  payload.
- m_axis_tkeep  output  NB  byte enables.
- m_axis_tlast  output  1  last beat of frame.
- m_axis_tvld  output  1  valid.
- m_axis_trdy  input  1  ready.

Behaviour:
- Reset: all outputs 0; state IDLE; counters cleared. Assertion is asynchronous and takes effect mid-frame with no flush. After release the block stays in IDLE until a new start.
- States:
  - IDLE -> SEND on i_start=1 with i_byte_len != 0. Start with len 0 is ignored: no busy, no done.
  - SEND -> GAP on last-beat handshake when more frames remain, stop is inactive and i_gap != 0.
  - SEND -> SEND (next frame) on last-beat handshake when more frames remain, stop is inactive and i_gap == 0.
  - SEND -> DONE on last-beat handshake when the frame count is reached or i_stop=1.
  - GAP -> SEND after exactly i_gap cycles with tvld=0. i_stop sampled during GAP -> DONE.
  - DONE -> IDLE after 1 cycle; o_done=1 in that cycle.
- Latency: start accepted at edge N -> first beat valid after edge N+1. Back-to-back beats at full rate when trdy=1.
- Beat b of a frame: lane i carries (seed + b*NB + i)[7:0] when b*NB + i < len. Unused lanes have tkeep=0 and tdata=0.
- Full beats have tkeep all ones. Last beat has tkeep = low (len - b*NB) bits set, tlast=1. tlast=0 on all other beats.
- Beats per frame = ceil(len/NB).
- AXI rule: once tvld=1, tdata/tkeep/tlast hold stable and tvld stays high until trdy=1. Next beat is presented in the cycle after the handshake edge.
- o_frame_cnt increments on each last-beat handshake and clears on accepted start.
- i_start while busy is ignored. Input changes after start have no effect except i_stop.
- i_stop never truncates a frame. Asserted in IDLE it has no effect.
- Counters: byte offset LEN_W bits, frame counter 16 bits, gap counter 16 bits, all unsigned.

Optional Feature:
- Macro: STR_SEQ_GEN_THROTTLE_EN.
- Defined: a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances every cycle. A new beat may raise tvld only in cycles where lfsr[0]=1. Once raised, tvld is held until handshake, so the AXI rule is preserved. Produces random source gaps.
- Not defined: no LFSR; tvld rises immediately whenever a beat is available.

Test Plan:
- NB=10, len=100, seed=0, frames=1, trdy=1 -> 10 beats, keep 0x3FF each; beat 9 carries bytes 90..99 with tlast=1; o_done pulses; o_frame_cnt=1.
- len=25 -> 3 beats; beat 2 keep 0x01F, bytes 20..24, upper lanes 0, tlast=1.
- trdy held low 5 cycles on beat 2 of a len=100 frame -> tvld/tdata/tkeep unchanged through the stall; no byte lost or duplicated.
- frames=3, gap=4, len=20, i_stop at the 2nd beat of frame 0 -> frame 0 completes, DONE, o_frame_cnt=1.
- frames=3, gap=4, len=20, no stop -> exactly 4 tvld=0 cycles between frames; o_frame_cnt=3; single o_done.
- seed=8'hFE, len=12 -> bytes FE,FF,00..09, wrap correct. Separately: i_rst_n low mid-frame -> all outputs 0 asynchronously, IDLE after release. Start with len=0 -> no output, no done.
